// File: rtl/cnt_seq_monitor.sv
// rtl/cnt_seq_monitor.sv - sequence monitor for a free-running up-counter (Q, TC)
//
// Purpose: samples an observed WIDTH-bit up-counter every clock, locks onto
// its count sequence, then flags value/TC errors and counts errors and wraps.
//
// Ports:
//   Clk       in   system clock, rising edge
//   MR        in   synchronous active-low reset of this block
//   En        in   monitor enable; low forces IDLE
//   Dut_mr    in   active-low reset of the observed counter
//   Q_in      in   observed counter value [WIDTH-1:0]
//   TC_in     in   observed terminal count
//   Clr_err   in   synchronous clear of Err_cnt and Err_code
//   Locked    out  high while in LOCK
//   Err       out  one-cycle pulse per detected error
//   Err_code  out  sticky cause of last error: 01 value, 10 TC, 11 both
//   Err_cnt   out  saturating error count [CNT_W-1:0]
//   Wrap_cnt  out  modulo count of observed wraps [CNT_W-1:0]

module cnt_seq_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CYC = 2,
  parameter int CNT_W    = 8
) (
  input  logic             Clk,
  input  logic             MR,
  input  logic             En,
  input  logic             Dut_mr,
  input  logic [WIDTH-1:0] Q_in,
  input  logic             TC_in,
  input  logic             Clr_err,
  output logic             Locked,
  output logic             Err,
  output logic [1:0]       Err_code,
  output logic [CNT_W-1:0] Err_cnt,
  output logic [CNT_W-1:0] Wrap_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCK    = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] Q_MAX    = '1;
  localparam logic [WIDTH-1:0] Q_ONE    = WIDTH'(1);
  localparam logic [2:0]       LOCK_TGT = 3'(LOCK_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] exp_q, exp_nx;
  logic [2:0]       match_q, match_nx;
  logic [2:0]       match_inc;
  logic             locked_nx;
  logic             err_nx;
  logic [1:0]       code_nx;
  logic [CNT_W-1:0] ecnt_nx;
  logic [CNT_W-1:0] wcnt_nx;
  logic [WIDTH-1:0] q_inc;
  logic             val_err;
  logic             tc_err;

  assign q_inc     = Q_in + Q_ONE;
  assign match_inc = match_q + 3'd1;
  assign val_err   = (Q_in != exp_q);
  // TC is judged against the observed value, not the expected one, so a
  // value error does not automatically drag a TC error along with it.
  assign tc_err    = (TC_in != (Q_in == Q_MAX));

  always_comb begin
    state_nx  = state;
    exp_nx    = exp_q;
    match_nx  = match_q;
    locked_nx = Locked;
    err_nx    = 1'b0;
    code_nx   = Clr_err ? 2'b00 : Err_code;
    ecnt_nx   = Clr_err ? '0 : Err_cnt;
    wcnt_nx   = Wrap_cnt;

    if (!En) begin
      state_nx  = S_IDLE;
      locked_nx = 1'b0;
    end else if (!Dut_mr) begin
      // Counter held in reset: its first count after release will be 1.
      state_nx  = S_ACQUIRE;
      exp_nx    = Q_ONE;
      match_nx  = 3'd0;
      locked_nx = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nx = S_ACQUIRE;
          exp_nx   = q_inc;
          match_nx = 3'd0;
        end

        S_ACQUIRE: begin
          if (!val_err) begin
            exp_nx   = exp_q + Q_ONE;
            match_nx = match_inc;
            if (match_inc == LOCK_TGT) begin
              state_nx  = S_LOCK;
              locked_nx = 1'b1;
              match_nx  = 3'd0;
            end
          end else begin
            // Resynchronise silently; errors only count once locked.
            exp_nx   = q_inc;
            match_nx = 3'd0;
          end
        end

        S_LOCK: begin
          if (val_err || tc_err) begin
            err_nx    = 1'b1;
            code_nx   = {tc_err, val_err};
            // A coincident clear restarts the count at this error.
            if (Clr_err)
              ecnt_nx = CNT_ONE;
            else if (Err_cnt != CNT_MAX)
              ecnt_nx = Err_cnt + CNT_ONE;
            else
              ecnt_nx = Err_cnt;
            state_nx  = S_ACQUIRE;
            exp_nx    = q_inc;
            match_nx  = 3'd0;
            locked_nx = 1'b0;
          end else begin
            exp_nx = exp_q + Q_ONE;
            if (Q_in == '0)
              wcnt_nx = Wrap_cnt + CNT_ONE;
          end
        end

        default: begin
          state_nx  = S_IDLE;
          locked_nx = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!MR) begin
      state    <= S_IDLE;
      exp_q    <= '0;
      match_q  <= 3'd0;
      Locked   <= 1'b0;
      Err      <= 1'b0;
      Err_code <= 2'b00;
      Err_cnt  <= '0;
      Wrap_cnt <= '0;
    end else begin
      state    <= state_nx;
      exp_q    <= exp_nx;
      match_q  <= match_nx;
      Locked   <= locked_nx;
      Err      <= err_nx;
      Err_code <= code_nx;
      Err_cnt  <= ecnt_nx;
      Wrap_cnt <= wcnt_nx;
    end
  end

endmodule
